// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable framing, feeding a small
// show-ahead FIFO with a valid/ready consumer interface.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_in,
  input  logic                          rx_ready,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = 4;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  logic [TCW-1:0] tcnt_q;
  logic           tick;
  logic [1:0]     sync_q;
  logic           rxs;

  assign tick = (tcnt_q == TCW'(DIV - 1));
  assign rxs  = sync_q[1];

  // Free-running divider; frame activity never realigns it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      sync_q <= 2'b11;
    end else begin
      tcnt_q <= tick ? '0 : tcnt_q + TCW'(1);
      sync_q <= {sync_q[0], serial_in};
    end
  end

  state_t               state_q;
  logic [SCW-1:0]       sc_q;
  logic [BCW-1:0]       bc_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 busy_q;
  logic                 sc_mid;
  logic                 sc_end;
  logic                 push;
  logic [EW-1:0]        push_word;

  assign sc_mid    = (sc_q == SCW'(OVERSAMPLE / 2 - 1));
  assign sc_end    = (sc_q == SCW'(OVERSAMPLE - 1));
  assign push      = tick && (state_q == S_STOP) && sc_end && (bc_q == BCW'(STOP_BITS - 1));
  // The last stop sample is folded in here because ferr_q only updates after it.
  assign push_word = {ferr_q | ~rxs, perr_q, shreg_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      bc_q    <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_q <= S_START;
            sc_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (sc_mid) begin
            if (rxs) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              sc_q    <= '0;
              bc_q    <= '0;
              perr_q  <= 1'b0;
              ferr_q  <= 1'b0;
            end
          end else begin
            sc_q <= sc_q + SCW'(1);
          end
        end
        S_DATA: begin
          if (sc_end) begin
            sc_q    <= '0;
            shreg_q <= {rxs, shreg_q[DATA_BITS-1:1]};
            if (bc_q == BCW'(DATA_BITS - 1)) begin
              bc_q    <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bc_q <= bc_q + BCW'(1);
            end
          end else begin
            sc_q <= sc_q + SCW'(1);
          end
        end
        S_PARITY: begin
          if (sc_end) begin
            sc_q    <= '0;
            perr_q  <= (PARITY == 1) ? ~(^shreg_q ^ rxs) : (^shreg_q ^ rxs);
            state_q <= S_STOP;
          end else begin
            sc_q <= sc_q + SCW'(1);
          end
        end
        S_STOP: begin
          if (sc_end) begin
            sc_q <= '0;
            if (!rxs) ferr_q <= 1'b1;
            if (bc_q == BCW'(STOP_BITS - 1)) begin
              state_q <= rxs ? S_IDLE : S_WAIT_IDLE;
              busy_q  <= ~rxs;
            end else begin
              bc_q <= bc_q + BCW'(1);
            end
          end else begin
            sc_q <= sc_q + SCW'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (rxs) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Handshake: an entry transfers on a clk edge where rx_valid and rx_ready are both high;
  // the head entry is held on the outputs until that edge.
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          ovr_q;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [EW-1:0] head;

  assign pop   = rx_valid & rx_ready;
  assign full  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
  assign wr_en = push & (~full | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + (AW + 1)'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - (AW + 1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= push_word;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      ovr_q <= push & full & ~pop;
    end
  end

  assign head          = mem_q[rd_q];
  assign rx_valid      = (cnt_q != '0);
  assign rx_data       = head[DATA_BITS-1:0];
  assign rx_parity_err = head[DATA_BITS];
  assign rx_frame_err  = head[DATA_BITS+1];
  assign rx_overrun    = ovr_q;
  assign fifo_count    = cnt_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1, 7E1 and 8N2 instances on one clock,
// 64 clk per bit (DIV=4, OVERSAMPLE=16).
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ser [3];
  logic rdy [3];
  int   total = 0;
  int   bad = 0;
  int   a_ov_cnt = 0;

  logic       a_valid, a_pe, a_fe, a_ov, a_busy;
  logic [7:0] a_data;
  logic [2:0] a_cnt;
  logic       b_valid, b_pe, b_fe, b_ov, b_busy;
  logic [6:0] b_data;
  logic [2:0] b_cnt;
  logic       c_valid, c_pe, c_fe, c_ov, c_busy;
  logic [7:0] c_data;
  logic [2:0] c_cnt;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(640000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .serial_in(ser[0]), .rx_ready(rdy[0]),
    .rx_valid(a_valid), .rx_data(a_data), .rx_parity_err(a_pe), .rx_frame_err(a_fe),
    .rx_overrun(a_ov), .fifo_count(a_cnt), .rx_busy(a_busy));

  uart_rx_fifo #(.CLK_FREQ(640000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .serial_in(ser[1]), .rx_ready(rdy[1]),
    .rx_valid(b_valid), .rx_data(b_data), .rx_parity_err(b_pe), .rx_frame_err(b_fe),
    .rx_overrun(b_ov), .fifo_count(b_cnt), .rx_busy(b_busy));

  uart_rx_fifo #(.CLK_FREQ(640000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .reset(reset), .serial_in(ser[2]), .rx_ready(rdy[2]),
    .rx_valid(c_valid), .rx_data(c_data), .rx_parity_err(c_pe), .rx_frame_err(c_fe),
    .rx_overrun(c_ov), .fifo_count(c_cnt), .rx_busy(c_busy));

  always @(negedge clk) if (a_ov === 1'b1) a_ov_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame ends at the centre of the last stop bit, line left at last_stop.
  task automatic send_frame(input int ln, input logic [8:0] data, input int nbits,
                            input int par, input bit flip, input int nstop, input logic last_stop);
    logic pb;
    ser[ln] = 1'b0;
    wait_clk(64);
    pb = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      ser[ln] = data[i];
      pb ^= data[i];
      wait_clk(64);
    end
    if (par != 0) begin
      if (par == 1) pb = ~pb;
      ser[ln] = pb ^ flip;
      wait_clk(64);
    end
    for (int s = 0; s < nstop; s++) begin
      ser[ln] = (s == nstop - 1) ? last_stop : 1'b1;
      wait_clk((s == nstop - 1) ? 32 : 64);
    end
  endtask

  task automatic pop(input int ln);
    rdy[ln] = 1'b1;
    @(negedge clk);
    rdy[ln] = 1'b0;
  endtask

  task automatic wait_a_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (a_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    wait_clk(3);
    total++; if (a_valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", a_valid); bad++; end
    total++; if (a_data !== 8'h00) begin $display("FAIL rst_data got=%h exp=00", a_data); bad++; end
    total++; if ({a_pe, a_fe, a_ov} !== 3'b000) begin $display("FAIL rst_flags got=%b exp=000", {a_pe, a_fe, a_ov}); bad++; end
    total++; if (a_cnt !== 3'd0) begin $display("FAIL rst_count got=%0d exp=0", a_cnt); bad++; end
    total++; if ({a_busy, b_busy, c_busy} !== 3'b000) begin $display("FAIL rst_busy got=%b exp=000", {a_busy, b_busy, c_busy}); bad++; end
    reset = 1'b1;
    wait_clk(10);
  endtask

  task automatic test_8n1;
    bit found;
    rdy[0] = 1'b1;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    wait_a_valid(70, found);
    total++; if (found !== 1'b1) begin $display("FAIL t1_timeout got=%b exp=1", found); bad++; end
    total++; if (a_data !== 8'hA5) begin $display("FAIL t1_data got=%h exp=a5", a_data); bad++; end
    total++; if ({a_pe, a_fe} !== 2'b00) begin $display("FAIL t1_flags got=%b exp=00", {a_pe, a_fe}); bad++; end
    @(negedge clk);
    total++; if (a_valid !== 1'b0) begin $display("FAIL t1_one_clk got=%b exp=0", a_valid); bad++; end
    rdy[0] = 1'b0;
    wait_clk(64);
  endtask

  task automatic test_parity;
    send_frame(1, 9'h035, 7, 2, 1'b0, 1, 1'b1);
    wait_clk(64);
    send_frame(1, 9'h035, 7, 2, 1'b1, 1, 1'b1);
    wait_clk(64);
    total++; if (b_cnt !== 3'd2) begin $display("FAIL t2_count got=%0d exp=2", b_cnt); bad++; end
    total++; if ({b_data, b_pe, b_fe} !== {7'h35, 2'b00}) begin $display("FAIL t2_first got=%h/%b%b exp=35/00", b_data, b_pe, b_fe); bad++; end
    pop(1);
    total++; if ({b_data, b_pe, b_fe} !== {7'h35, 2'b10}) begin $display("FAIL t2_second got=%h/%b%b exp=35/10", b_data, b_pe, b_fe); bad++; end
    pop(1);
    total++; if (b_valid !== 1'b0) begin $display("FAIL t2_empty got=%b exp=0", b_valid); bad++; end
  endtask

  task automatic test_two_stop;
    bit dropped;
    bit found;
    send_frame(2, 9'h00F, 8, 0, 1'b0, 2, 1'b0);
    dropped = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (c_busy !== 1'b1) dropped = 1'b1;
    end
    total++; if (dropped !== 1'b0) begin $display("FAIL t3_busy_held got=%b exp=0", dropped); bad++; end
    total++; if (c_cnt !== 3'd1) begin $display("FAIL t3_count_low got=%0d exp=1", c_cnt); bad++; end
    ser[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c_busy === 1'b0) begin found = 1'b1; break; end
    end
    total++; if (found !== 1'b1) begin $display("FAIL t3_busy_release got=%b exp=1", found); bad++; end
    wait_clk(128);
    total++; if (c_cnt !== 3'd1) begin $display("FAIL t3_count got=%0d exp=1", c_cnt); bad++; end
    total++; if ({c_data, c_pe, c_fe} !== {8'h0F, 2'b01}) begin $display("FAIL t3_entry got=%h/%b%b exp=0f/01", c_data, c_pe, c_fe); bad++; end
    pop(2);
    total++; if (c_cnt !== 3'd0) begin $display("FAIL t3_drain got=%0d exp=0", c_cnt); bad++; end
  endtask

  task automatic test_overrun;
    int base;
    logic [7:0] exp_d;
    base = a_ov_cnt;
    for (int k = 1; k <= 4; k++) begin
      exp_d = 8'(k);
      send_frame(0, {1'b0, exp_d}, 8, 0, 1'b0, 1, 1'b1);
      wait_clk(64);
    end
    total++; if (a_cnt !== 3'd4) begin $display("FAIL t4_count4 got=%0d exp=4", a_cnt); bad++; end
    total++; if (a_ov_cnt - base !== 0) begin $display("FAIL t4_no_ovr got=%0d exp=0", a_ov_cnt - base); bad++; end
    send_frame(0, 9'h005, 8, 0, 1'b0, 1, 1'b1);
    wait_clk(64);
    total++; if (a_ov_cnt - base !== 1) begin $display("FAIL t4_ovr_pulse got=%0d exp=1", a_ov_cnt - base); bad++; end
    total++; if (a_cnt !== 3'd4) begin $display("FAIL t4_count_after got=%0d exp=4", a_cnt); bad++; end
    for (int k = 1; k <= 4; k++) begin
      exp_d = 8'(k);
      total++; if (a_data !== exp_d) begin $display("FAIL t4_drain got=%h exp=%h", a_data, exp_d); bad++; end
      pop(0);
    end
    total++; if (a_cnt !== 3'd0) begin $display("FAIL t4_empty got=%0d exp=0", a_cnt); bad++; end
  endtask

  task automatic test_full_pop;
    int base;
    bit found;
    logic [7:0] exp_q [$];
    logic [7:0] exp_d;
    exp_q = '{8'h20, 8'h30, 8'h40, 8'h77};
    send_frame(0, 9'h010, 8, 0, 1'b0, 1, 1'b1); wait_clk(64);
    send_frame(0, 9'h020, 8, 0, 1'b0, 1, 1'b1); wait_clk(64);
    send_frame(0, 9'h030, 8, 0, 1'b0, 1, 1'b1); wait_clk(64);
    send_frame(0, 9'h040, 8, 0, 1'b0, 1, 1'b1); wait_clk(64);
    total++; if (a_cnt !== 3'd4) begin $display("FAIL t6_full got=%0d exp=4", a_cnt); bad++; end
    base = a_ov_cnt;
    send_frame(0, 9'h077, 8, 0, 1'b0, 1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (u_a.push === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (found !== 1'b1) begin $display("FAIL t6_push_timeout got=%b exp=1", found); bad++; end
    pop(0);
    total++; if (a_cnt !== 3'd4) begin $display("FAIL t6_count got=%0d exp=4", a_cnt); bad++; end
    wait_clk(64);
    total++; if (a_ov_cnt - base !== 0) begin $display("FAIL t6_no_ovr got=%0d exp=0", a_ov_cnt - base); bad++; end
    while (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      total++; if (a_data !== exp_d) begin $display("FAIL t6_order got=%h exp=%h", a_data, exp_d); bad++; end
      pop(0);
    end
    total++; if (a_valid !== 1'b0) begin $display("FAIL t6_empty got=%b exp=0", a_valid); bad++; end
  endtask

  task automatic test_glitch;
    bit saw_busy;
    saw_busy = 1'b0;
    ser[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_busy === 1'b1) saw_busy = 1'b1;
    end
    ser[0] = 1'b1;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if (a_busy === 1'b1) saw_busy = 1'b1;
    end
    total++; if (saw_busy !== 1'b1) begin $display("FAIL t5_glitch_seen got=%b exp=1", saw_busy); bad++; end
    total++; if (a_busy !== 1'b0) begin $display("FAIL t5_glitch_idle got=%b exp=0", a_busy); bad++; end
    wait_clk(128);
    total++; if (a_cnt !== 3'd0) begin $display("FAIL t5_glitch_push got=%0d exp=0", a_cnt); bad++; end
  endtask

  task automatic test_reset_mid;
    bit found;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    wait_clk(40);
    total++; if (a_cnt !== 3'd1) begin $display("FAIL t7_pre_count got=%0d exp=1", a_cnt); bad++; end
    ser[0] = 1'b0; wait_clk(64);
    ser[0] = 1'b1; wait_clk(64);
    ser[0] = 1'b0; wait_clk(30);
    total++; if (a_busy !== 1'b1) begin $display("FAIL t7_pre_busy got=%b exp=1", a_busy); bad++; end
    #2 reset = 1'b0;
    #1;
    total++; if ({a_valid, a_pe, a_fe, a_ov, a_busy} !== 5'b0) begin $display("FAIL t7_rst_flags got=%b exp=00000", {a_valid, a_pe, a_fe, a_ov, a_busy}); bad++; end
    total++; if ({a_data, a_cnt} !== 11'd0) begin $display("FAIL t7_rst_data got=%h/%0d exp=00/0", a_data, a_cnt); bad++; end
    ser[0] = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(20);
    rdy[0] = 1'b1;
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1);
    wait_a_valid(70, found);
    total++; if (found !== 1'b1) begin $display("FAIL t7_timeout got=%b exp=1", found); bad++; end
    total++; if ({a_data, a_pe, a_fe} !== {8'h3C, 2'b00}) begin $display("FAIL t7_data got=%h/%b%b exp=3c/00", a_data, a_pe, a_fe); bad++; end
    rdy[0] = 1'b0;
    wait_clk(64);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ser[i] = 1'b1;
      rdy[i] = 1'b0;
    end
    test_reset;
    test_8n1;
    test_parity;
    test_two_stop;
    test_overrun;
    test_full_pop;
    test_glitch;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
